// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory port arbiter: FSM states, grant codes,
// stall vector bit positions and the latched RAM command record.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_ACC  = 2'd1,
        ST_MEM_ACC = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_MEM  = 2'b10;

    localparam int STALL_IF  = 1;
    localparam int STALL_MEM = 4;

    localparam logic [3:0] SEL_FETCH = 4'b1111;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshaked single-port RAM bus; the arbiter is the master, the RAM the slave.
interface mem_port_arbiter_if;

    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        ram_ack_i;

    modport master (
        output ram_req_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o,
        input  ram_rdata_i, ram_ack_i
    );

    modport slave (
        input  ram_req_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o,
        output ram_rdata_i, ram_ack_i
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and MEM-stage accesses onto one handshaked RAM
// port, holding each result until the owning stage advances.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall_i,
    input  logic               if_ce_i,
    input  logic [31:0]        if_addr_i,
    output logic [31:0]        if_inst_o,
    output logic               if_stallreq_o,
    input  logic               mem_ce_i,
    input  logic               mem_we_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [3:0]         mem_sel_i,
    input  logic [31:0]        mem_data_i,
    output logic [31:0]        mem_data_o,
    output logic               mem_stallreq_o,
    mem_port_arbiter_if.master ram,
    output logic               bus_err_o,
    output logic [1:0]         grant_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    ram_cmd_t         cmd_q, cmd_d;
    logic [1:0]       grant_d;
    logic [31:0]      if_inst_d, mem_data_d;
    logic             bus_err_d;
    logic             if_done_q, if_done_d, mem_done_q, mem_done_d;
    logic             if_set, mem_set, finish;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    logic unused_stall;
    assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

    assign if_stallreq_o  = if_ce_i & ~if_done_q;
    assign mem_stallreq_o = mem_ce_i & ~mem_done_q;

    assign ram.ram_req_o   = cmd_q.req;
    assign ram.ram_we_o    = cmd_q.we;
    assign ram.ram_addr_o  = cmd_q.addr;
    assign ram.ram_sel_o   = cmd_q.sel;
    assign ram.ram_wdata_o = cmd_q.wdata;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        grant_d    = grant_o;
        if_inst_d  = if_inst_o;
        mem_data_d = mem_data_o;
        bus_err_d  = 1'b0;
        cnt_d      = cnt_q;
        if_set     = 1'b0;
        mem_set    = 1'b0;
        finish     = ram.ram_ack_i | (cnt_q == TMO_LAST);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // MEM holds the older instruction, so it wins a tie.
                if (mem_ce_i & ~mem_done_q) begin
                    cmd_d   = '{req: 1'b1, we: mem_we_i, addr: mem_addr_i,
                                sel: mem_sel_i, wdata: mem_data_i};
                    grant_d = GNT_MEM;
                    state_d = ST_MEM_ACC;
                end else if (if_ce_i & ~if_done_q) begin
                    cmd_d   = '{req: 1'b1, we: 1'b0, addr: if_addr_i,
                                sel: SEL_FETCH, wdata: 32'h0};
                    grant_d = GNT_IF;
                    state_d = ST_IF_ACC;
                end
            end
            ST_IF_ACC, ST_MEM_ACC: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (finish) begin
                    cmd_d.req = 1'b0;
                    grant_d   = GNT_NONE;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                    // An ack landing on the last timeout cycle still counts.
                    bus_err_d = ~ram.ram_ack_i;
                    if (state_q == ST_IF_ACC) begin
                        if_set    = 1'b1;
                        if_inst_d = ram.ram_ack_i ? ram.ram_rdata_i : 32'h0;
                    end else begin
                        mem_set = 1'b1;
                        if (!cmd_q.we)
                            mem_data_d = ram.ram_ack_i ? ram.ram_rdata_i : 32'h0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if_done_d  = if_set  | (if_done_q  & stall_i[STALL_IF]);
        mem_done_d = mem_set | (mem_done_q & stall_i[STALL_MEM]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            grant_o    <= GNT_NONE;
            if_inst_o  <= '0;
            mem_data_o <= '0;
            bus_err_o  <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            grant_o    <= grant_d;
            if_inst_o  <= if_inst_d;
            mem_data_o <= mem_data_d;
            bus_err_o  <= bus_err_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, then randomized rounds against an access-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        if_ce, mem_ce, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_inst, mem_data;
    logic        if_stallreq, mem_stallreq, bus_err;
    logic [1:0]  grant;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if ram ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .stall_i(stall),
        .if_ce_i(if_ce), .if_addr_i(if_addr), .if_inst_o(if_inst),
        .if_stallreq_o(if_stallreq),
        .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_sel_i(mem_sel), .mem_data_i(mem_wdata), .mem_data_o(mem_data),
        .mem_stallreq_o(mem_stallreq),
        .ram(ram), .bus_err_o(bus_err), .grant_o(grant)
    );

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } acc_t;

    vec_t        vt[8];
    logic [31:0] exp_inst, exp_mdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic release_all();
        @(negedge clk);
        ram.ram_ack_i = 1'b0;
        if_ce = 1'b0; mem_ce = 1'b0; mem_we = 1'b0; stall = '0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          cyc;
        logic [1:0]  g;
        logic [3:0]  s;
        @(negedge clk);
        if (v.is_mem) begin
            mem_ce = 1'b1; mem_we = v.we; mem_addr = v.addr;
            mem_sel = v.sel; mem_wdata = v.wdata; stall = 6'b011111;
        end else begin
            if_ce = 1'b1; if_addr = v.addr; stall = 6'b000011;
        end
        #1;
        check($sformatf("vec%0d stallreq", id), 32'(v.is_mem ? mem_stallreq : if_stallreq), 32'd1);
        g   = v.is_mem ? GNT_MEM : GNT_IF;
        s   = v.is_mem ? v.sel : 4'hF;
        cyc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ram.ram_ack_i = 1'b0;
            if (!ram.ram_req_o) break;
            check($sformatf("vec%0d addr", id), ram.ram_addr_o, v.addr);
            check($sformatf("vec%0d gnt/we/sel", id),
                  32'({grant, ram.ram_we_o, ram.ram_sel_o}), 32'({g, v.is_mem & v.we, s}));
            if (v.is_mem && v.we) check($sformatf("vec%0d wdata", id), ram.ram_wdata_o, v.wdata);
            if (cyc == v.delay) begin
                ram.ram_ack_i = 1'b1; ram.ram_rdata_i = v.rdata;
            end
            cyc++;
        end
        check($sformatf("vec%0d acc cycles", id), 32'(cyc), 32'(v.exp_cyc));
        check($sformatf("vec%0d result", id), v.is_mem ? mem_data : if_inst, v.exp_res);
        check($sformatf("vec%0d stall drop", id), 32'(v.is_mem ? mem_stallreq : if_stallreq), 32'd0);
        check($sformatf("vec%0d bus_err", id), 32'(bus_err), 32'(v.exp_err));
        check($sformatf("vec%0d grant idle", id), 32'(grant), 32'(GNT_NONE));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("vec%0d hold", id),
                  {v.is_mem ? mem_data[30:0] : if_inst[30:0], ram.ram_req_o | bus_err},
                  {v.exp_res[30:0], 1'b0});
        end
        release_all();
    endtask

    task automatic rand_round(input int r);
        acc_t        q[$];
        acc_t        a, cur;
        int          pick, d_if, d_mem, exp_err, errs, idx, n_iss, exp_n;
        logic        do_if, do_mem, mwe, prev_req, fin;
        logic [31:0] ia, ma, wd, rd_if, rd_mem;
        logic [3:0]  ms;
        pick   = int'($urandom_range(1, 3));
        do_mem = (pick & 2) != 0;
        do_if  = (pick & 1) != 0;
        mwe    = 1'($urandom_range(0, 1));
        ms     = 4'($urandom_range(1, 15));
        ia = $urandom; ma = $urandom; wd = $urandom; rd_if = $urandom; rd_mem = $urandom;
        d_if  = int'($urandom_range(0, 5));
        d_mem = int'($urandom_range(0, 5));
        // Model: MEM first when both pend; ack within TMO cycles returns data,
        // otherwise the access aborts with a zero read result and one error.
        exp_err = 0; exp_n = 0;
        if (do_mem) begin
            a = '{GNT_MEM, mwe, ma, ms, wd, rd_mem, d_mem};
            q.push_back(a); exp_n++;
            if (d_mem >= TMO) exp_err++;
            if (!mwe) exp_mdata = (d_mem < TMO) ? rd_mem : 32'h0;
        end
        if (do_if) begin
            a = '{GNT_IF, 1'b0, ia, 4'hF, 32'h0, rd_if, d_if};
            q.push_back(a); exp_n++;
            if (d_if >= TMO) exp_err++;
            exp_inst = (d_if < TMO) ? rd_if : 32'h0;
        end
        @(negedge clk);
        if_ce = do_if; if_addr = ia;
        mem_ce = do_mem; mem_we = mwe; mem_addr = ma; mem_sel = ms; mem_wdata = wd;
        stall = do_mem ? 6'b011111 : 6'b000011;
        prev_req = 1'b0; errs = 0; idx = 0; n_iss = 0; fin = 1'b0;
        cur = '{GNT_NONE, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ram.ram_ack_i = 1'b0;
            if (bus_err) errs++;
            if (!if_stallreq && !mem_stallreq) begin fin = 1'b1; break; end
            if (ram.ram_req_o) begin
                if (!prev_req) begin
                    n_iss++;
                    if (q.size() > 0) cur = q.pop_front();
                    idx = 0;
                    check($sformatf("rnd%0d addr", r), ram.ram_addr_o, cur.addr);
                    check($sformatf("rnd%0d gnt/we/sel", r),
                          32'({grant, ram.ram_we_o, ram.ram_sel_o}), 32'({cur.gnt, cur.we, cur.sel}));
                    if (cur.we) check($sformatf("rnd%0d wdata", r), ram.ram_wdata_o, cur.wdata);
                end else idx++;
                if (idx == cur.delay) begin
                    ram.ram_ack_i = 1'b1; ram.ram_rdata_i = cur.rdata;
                end
            end
            prev_req = ram.ram_req_o;
        end
        check($sformatf("rnd%0d completed", r), 32'(fin), 32'd1);
        check($sformatf("rnd%0d issued", r), 32'(n_iss), 32'(exp_n));
        check($sformatf("rnd%0d bus_err count", r), 32'(errs), 32'(exp_err));
        check($sformatf("rnd%0d if_inst", r), if_inst, exp_inst);
        check($sformatf("rnd%0d mem_data", r), mem_data, exp_mdata);
        release_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst = 1'b1; stall = '0; if_ce = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
        ram.ram_ack_i = 1'b0; ram.ram_rdata_i = '0;

        vt[0] = '{1'b0, 1'b0, 32'h100, 4'hF, 32'h0,        32'h34010020, 0, 32'h34010020, 1'b0, 1};
        vt[1] = '{1'b1, 1'b0, 32'h2000, 4'hF, 32'h0,       32'h11223344, 2, 32'h11223344, 1'b0, 3};
        vt[2] = '{1'b1, 1'b1, 32'h200, 4'b0011, 32'hDEADBEEF, 32'hAAAA5555, 1, 32'h11223344, 1'b0, 2};
        vt[3] = '{1'b1, 1'b0, 32'h300, 4'hF, 32'h0,        32'h77777777, 9, 32'h0,        1'b1, 4};
        vt[4] = '{1'b0, 1'b0, 32'h104, 4'hF, 32'h0,        32'hCAFEF00D, 3, 32'hCAFEF00D, 1'b0, 4};
        vt[5] = '{1'b1, 1'b0, 32'h400, 4'hF, 32'h0,        32'h0BADF00D, 0, 32'h0BADF00D, 1'b0, 1};
        vt[6] = '{1'b1, 1'b1, 32'h404, 4'b1100, 32'h12345678, 32'h99999999, 7, 32'h0BADF00D, 1'b1, 4};
        vt[7] = '{1'b0, 1'b0, 32'h108, 4'hF, 32'h0,        32'h55555555, 5, 32'h0,        1'b1, 4};

        #12;
        check("reset ctl", 32'({ram.ram_req_o, ram.ram_we_o, ram.ram_sel_o, grant, bus_err}), 32'd0);
        check("reset addr", ram.ram_addr_o, 32'h0);
        check("reset data", if_inst | mem_data, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Simultaneous requests: MEM first, bubble, then IF.
        @(negedge clk);
        if_ce = 1'b1; if_addr = 32'h104;
        mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_sel = 4'hF; stall = 6'b011111;
        #1 check("both stallreq", 32'({if_stallreq, mem_stallreq}), 32'b11);
        @(negedge clk);
        check("both first addr", ram.ram_addr_o, 32'h2000);
        check("both first gnt", 32'({ram.ram_req_o, grant}), 32'b110);
        ram.ram_ack_i = 1'b1; ram.ram_rdata_i = 32'h55AA1234;
        @(negedge clk);
        ram.ram_ack_i = 1'b0;
        check("both bubble", 32'({ram.ram_req_o, if_stallreq, mem_stallreq}), 32'b010);
        check("both mem data", mem_data, 32'h55AA1234);
        @(negedge clk);
        check("both second addr", ram.ram_addr_o, 32'h104);
        check("both second gnt", 32'({ram.ram_req_o, grant, ram.ram_sel_o}), 32'b1_01_1111);
        ram.ram_ack_i = 1'b1; ram.ram_rdata_i = 32'h24020005;
        @(negedge clk);
        ram.ram_ack_i = 1'b0;
        check("both stall drop", 32'({if_stallreq, mem_stallreq}), 32'b00);
        check("both if inst", if_inst, 32'h24020005);
        release_all();

        // Fetch done while IF frozen: single access, stable result, then refetch.
        @(negedge clk);
        if_ce = 1'b1; if_addr = 32'h500; stall = 6'b000011;
        pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            ram.ram_ack_i = 1'b0;
            if (ram.ram_req_o) begin
                pulses++; ram.ram_ack_i = 1'b1; ram.ram_rdata_i = 32'h8C220000;
            end
            if (k >= 2) check($sformatf("hold inst c%0d", k), if_inst, 32'h8C220000);
        end
        check("hold req pulses", 32'(pulses), 32'd1);
        stall = 6'b000000; if_addr = 32'h504;
        @(negedge clk);
        stall = 6'b000011;
        check("refetch pending", 32'({if_stallreq, ram.ram_req_o}), 32'b10);
        @(negedge clk);
        check("refetch addr", ram.ram_addr_o, 32'h504);
        check("refetch req", 32'(ram.ram_req_o), 32'd1);
        ram.ram_ack_i = 1'b1; ram.ram_rdata_i = 32'h3C011000;
        @(negedge clk);
        ram.ram_ack_i = 1'b0;
        check("refetch inst", if_inst, 32'h3C011000);
        release_all();

        // Asynchronous reset in the middle of a MEM access.
        @(negedge clk);
        mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h600; mem_sel = 4'hF; stall = 6'b011111;
        @(negedge clk);
        check("pre-reset req", 32'(ram.ram_req_o), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst ctl", 32'({ram.ram_req_o, ram.ram_we_o, ram.ram_sel_o, grant, bus_err}), 32'd0);
        check("async rst addr", ram.ram_addr_o, 32'h0);
        check("async rst data", if_inst | mem_data, 32'h0);
        check("async rst stallreq", 32'(mem_stallreq), 32'd1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("reissue addr", ram.ram_addr_o, 32'h600);
        check("reissue gnt", 32'({ram.ram_req_o, grant}), 32'b110);
        ram.ram_ack_i = 1'b1; ram.ram_rdata_i = 32'h0000BEEF;
        @(negedge clk);
        ram.ram_ack_i = 1'b0;
        check("reissue data", mem_data, 32'h0000BEEF);
        release_all();

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_inst = 32'h0; exp_mdata = 32'h0;
        for (int r = 0; r < 40; r++) rand_round(r);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, handshaked instruction/data memory between two requesters: instruction fetch (PC stage) and the MEM stage.
- Serialises accesses and raises per-requester stall requests toward ctrl.
- Holds each completed result until the owning pipeline stage advances.
- Sits between pc_reg/if_id/mem and the external RAM, replacing the separate ROM port.

Parameters:
TIMEOUT_CYCLES, 255, max cycles an access waits for ram_ack_i before abort (1..255)
TMO_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
stall_i  in  6  stall vector from ctrl; bit1 = IF frozen, bit4 = MEM frozen
if_ce_i  in  1  fetch request (pc_reg ce)
if_addr_i  in  32  fetch byte address (pc)
if_inst_o  out  32  fetched instruction to if_id
if_stallreq_o  out  1  fetch not yet complete
mem_ce_i  in  1  data access request
mem_we_i  in  1  1 = write
mem_addr_i  in  32  data byte address
mem_sel_i  in  4  byte enables
mem_data_i  in  32  store data
mem_data_o  out  32  load data
mem_stallreq_o  out  1  data access not yet complete
ram_req_o  out  1  access valid to RAM
ram_we_o  out  1  write strobe
ram_addr_o  out  32  address
ram_sel_o  out  4  byte enables (4'b1111 for fetch)
ram_wdata_o  out  32  write data
ram_rdata_i  in  32  read data, valid with ack
ram_ack_i  in  1  access complete, single-cycle pulse
bus_err_o  out  1  one-cycle pulse on timeout abort
grant_o  out  2  current owner: 00 none, 01 IF, 10 MEM

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; all outputs 0; if_done, mem_done, timeout counter cleared. An outstanding RAM access is abandoned; ram_req_o drops without waiting for ack.
- All ram_* outputs, grant_o, if_inst_o, mem_data_o and bus_err_o are registered.
- Stall requests are combinational:
  - if_stallreq_o = if_ce_i & ~if_done
  - mem_stallreq_o = mem_ce_i & ~mem_done
- States:
  - IDLE:
    - If mem_ce_i & ~mem_done: latch the MEM request onto ram_*, ram_req_o=1, grant=10, go MEM_ACC.
    - Else if if_ce_i & ~if_done: latch if_addr_i, sel=1111, we=0, ram_req_o=1, grant=01, go IF_ACC.
    - Else stay.
    - When both requests are pending, MEM has fixed priority because it is the older instruction.
  - MEM_ACC / IF_ACC:
    - Hold ram_* stable and increment the counter each cycle.
    - On ram_ack_i: latch ram_rdata_i into mem_data_o (reads only; writes leave mem_data_o unchanged) or into if_inst_o. Set the matching done flag, ram_req_o=0, grant=00, counter=0, go IDLE.
    - If the counter reaches TIMEOUT_CYCLES-1 without ack: abort, load result 0 (reads), set done, pulse bus_err_o, go IDLE.
    - An ack in the same cycle as the timeout counts as an ack.
- Latency: the request is seen in cycle 0; ram_req_o is high from cycle 1; ack is earliest in cycle 1; result and done are valid in cycle 2, and the stall request drops in cycle 2. Minimum is 2 stall cycles per access.
- Done flags:
  - mem_done clears on the clock edge where stall_i[4]=0; if_done clears on the edge where stall_i[1]=0.
  - Set has priority over clear in the same cycle.
- Hold: while if_done=1 and stall_i[1]=1, if_inst_o is stable and no refetch occurs. mem_data_o behaves the same way with stall_i[4].
- No back-to-back issue: IDLE always separates two accesses (one bubble cycle).
- ram_ack_i received in IDLE is ignored.
- Requesters keep their inputs stable while their stall request is high; the arbiter does not re-check them mid-access.

Decomposition:
- defines.v gains: state encodings (IDLE/IF_ACC/MEM_ACC), grant codes, stall bit indices (IF=1, MEM=4) and the fetch byte-enable constant.
- Single module; the timeout counter is inline, so no sub-module.

Test Plan:
1. IF-only: if_addr=0x100, ack in cycle 1 with rdata 0x34010020 -> ram_req_o=1, ram_addr=0x100, sel=1111 in cycle 1; if_inst_o=0x34010020 and if_stallreq_o=0 in cycle 2.
2. Simultaneous IF (0x104) and MEM read (0x2000) -> MEM granted first (grant=10, addr 0x2000); IF issued only after the return to IDLE; both stall requests low only after both dones are set.
3. MEM write: addr 0x200, sel 0011, data 0xDEADBEEF -> ram_we_o=1, ram_wdata_o=0xDEADBEEF, ram_sel_o=0011; mem_data_o unchanged.
4. Hold: fetch completes while stall_i[1]=1 for 3 cycles -> exactly one ram_req pulse and if_inst_o stable; after stall_i[1]=0, a new fetch is issued the next cycle.
5. Timeout: TIMEOUT_CYCLES=4, no ack -> ram_req_o drops after 4 cycles in ACC, bus_err_o pulses once, mem_data_o=0, mem_stallreq_o falls.
6. Reset asserted mid MEM_ACC between clock edges -> all outputs 0 immediately; after release the state is IDLE and the still-pending request is reissued.
